uart_file_loader: RTL
=====================

Name: uart_file_loader

Overview:
Device-side engine for the host file-transfer protocol over a byte-level UART stream. On start it sends request code 0x02 to the host. It then receives a 4-byte little-endian file size, followed by that many payload bytes. Payload bytes are packed little-endian into 32-bit words and written through a simple memory write port. It sits between the UART byte interface and the boot/main RAM, and replaces the software loader for program and data images.

Parameters:
ADDR_W, 32, width of the memory word-address base and write address (byte address)
DATA_W, 32, memory data width (fixed at 32; other values are unsupported)
MAX_SIZE, 2**20, largest accepted file size in bytes; a larger size is an error
REQ_CHAR, 8'h02, request code transmitted to the host

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a transfer when idle, ignored otherwise
base_addr  in  ADDR_W  byte address of the first word; bits [1:0] are ignored (treated as 0)
tx_valid  out  1  byte available to the UART transmitter
tx_data  out  8  byte to transmit
tx_ready  in  1  transmitter accepts tx_data
rx_valid  in  1  received byte available
rx_data  in  8  received byte
rx_ready  out  1  loader consumes rx_data
mem_valid  out  1  write request
mem_addr  out  ADDR_W  byte address of the word being written
mem_wdata  out  32  packed word
mem_wstrb  out  4  byte enables
mem_ready  in  1  write accepted
busy  out  1  high from the start acceptance cycle until done or error
done  out  1  single-cycle pulse on successful completion
error  out  1  sticky until the next accepted start; set when size is 0 or size > MAX_SIZE
file_size  out  32  size field received; valid from the SIZE to DATA transition

Behaviour:
- Reset (async, resetn=0): state IDLE. All of the following are 0: tx_valid, tx_data, rx_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, busy, done, error, file_size. Internal counters are cleared. Reset mid-transfer aborts with no further memory writes.
- Handshakes: a transfer occurs on a clk edge with valid&ready. A valid output holds its data stable until accepted.
- States:
  - IDLE: start=1 -> REQ. This clears error, sets busy, and latches base_addr[ADDR_W-1:2]<<2 as the write pointer.
  - REQ: tx_valid=1, tx_data=REQ_CHAR. On tx_ready -> SIZE.
  - SIZE: rx_ready=1. Bytes are shifted into file_size LSB first; byte k goes to [8k+7:8k]. After the 4th byte: size==0 or size>MAX_SIZE -> ERR; otherwise -> DATA with remaining=size.
  - DATA: rx_ready=1 only when the pack buffer is not holding a pending word (mem_valid=0).
    - Byte i of each word goes to lane i and sets wstrb[i]; remaining decrements.
    - When lane 3 is filled, or remaining reaches 0, mem_valid rises on the next cycle.
    - On mem_ready: pointer += 4, and the lane and strobes clear.
    - If remaining==0 when the write completes -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
  - ERR: error=1, busy=0 -> IDLE. No memory writes occur in an error transfer.
- Last partial word: mem_wstrb has only the filled lanes set (size%4==1 -> 4'b0001, 2 -> 4'b0011, 3 -> 4'b0111). Unfilled lanes of mem_wdata are 0. Full words use 4'hF.
- Throughput: one byte per cycle when rx_valid is continuous and mem_ready is tied high. A word write costs 1 stall cycle on rx_ready.
- Counters: remaining is 32-bit. The pointer wraps modulo 2**ADDR_W with no error.
- start while busy: ignored.
- rx_valid while not in SIZE/DATA: rx_ready=0; the byte is left in the UART and not dropped.
- mem_valid and rx_ready are never both 1 in the same cycle.
- tx_valid is high only in REQ.

Test Plan:
- Reset mid-DATA: assert resetn=0 after 5 payload bytes -> all outputs 0 asynchronously; no mem_valid after release until a new start.
- Nominal: start, base_addr=0x100, host sees 0x02, sends size bytes 08 00 00 00 then 11 22 33 44 55 66 77 88 -> writes (0x100, 0x44332211, F), (0x104, 0x88776655, F); done pulses once; file_size=8; error=0.
- Partial tail: size=6, bytes A0..A5 -> second write is addr base+4, data 0x0000A5A4, wstrb 4'b0011.
- Backpressure: mem_ready held low for 10 cycles on the first word -> rx_ready=0 during those cycles, mem_wdata stable, no byte lost; final memory contents match.
- Size error: size bytes 00 00 00 00, then separately size=MAX_SIZE+1 -> error=1, done=0, no mem_valid; a following good start clears error.
- Slow tx and spurious start: tx_ready delayed 7 cycles -> tx_data held at 0x02; a start pulse during DATA has no effect on pointer or counters.

Source files
------------

// File: rtl/uart_file_loader.sv
// ---------------------------------------------------------------------------
// uart_file_loader
//
// Device-side engine for the host file-transfer protocol on a byte UART.
// It sends a request code, receives a 4-byte little-endian size, then packs
// that many payload bytes little-endian into 32-bit words and writes them out
// through a valid/ready memory write port.
//
// Ports
//   clk, resetn            system clock, asynchronous active-low reset
//   start, base_addr       begin a transfer at byte address base_addr (word aligned)
//   tx_valid/tx_data/tx_ready   request byte towards the UART transmitter
//   rx_valid/rx_data/rx_ready   bytes from the UART receiver
//   mem_valid/mem_addr/mem_wdata/mem_wstrb/mem_ready   word write port
//   busy, done, error      status (done is a pulse, error is sticky)
//   file_size              size field received from the host
//
// State | Meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// REQ   | presenting REQ_CHAR on tx until accepted
// SIZE  | shifting in the 4 size bytes, LSB first
// DATA  | packing payload bytes; a full or final word is held on mem_*
// DONE  | one-cycle done pulse
// ERR   | bad size; error set, no memory writes
// ---------------------------------------------------------------------------
module uart_file_loader #(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter int          MAX_SIZE = 2**20,
    parameter logic [7:0]  REQ_CHAR = 8'h02
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  mem_valid,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           file_size
);

    localparam int STRB_W = DATA_W / 8;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_SIZE = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    logic [2:0]        state_q,     state_d;
    logic [ADDR_W-1:0] ptr_q,       ptr_d;
    logic [31:0]       rem_q,       rem_d;
    logic [31:0]       size_q,      size_d;
    logic [1:0]        size_cnt_q,  size_cnt_d;
    logic [1:0]        lane_q,      lane_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic [STRB_W-1:0] wstrb_q,     wstrb_d;
    logic              mem_valid_q, mem_valid_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              error_q,     error_d;

    logic [31:0]       full_size;

    // rx is only offered while a byte can actually be absorbed; in DATA the
    // pack buffer must be free, which keeps rx_ready and mem_valid exclusive.
    assign rx_ready  = (state_q == ST_SIZE) ||
                       ((state_q == ST_DATA) && !mem_valid_q && (rem_q != 32'd0));
    assign tx_valid  = (state_q == ST_REQ);
    assign tx_data   = (state_q == ST_REQ) ? REQ_CHAR : 8'h00;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = ptr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign file_size = size_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        size_d      = size_q;
        size_cnt_d  = size_cnt_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        mem_valid_d = mem_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        full_size   = {rx_data, size_q[23:0]};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_REQ;
                    busy_d      = 1'b1;
                    error_d     = 1'b0;
                    ptr_d       = base_addr & ~ADDR_W'(3);
                    rem_d       = 32'd0;
                    size_d      = 32'd0;
                    size_cnt_d  = 2'd0;
                    lane_d      = 2'd0;
                    wdata_d     = '0;
                    wstrb_d     = '0;
                    mem_valid_d = 1'b0;
                end
            end

            ST_REQ: begin
                if (tx_ready) begin
                    state_d = ST_SIZE;
                end
            end

            ST_SIZE: begin
                if (rx_valid) begin
                    size_d[8*size_cnt_q +: 8] = rx_data;
                    size_cnt_d = size_cnt_q + 2'd1;
                    if (size_cnt_q == 2'd3) begin
                        if ((full_size == 32'd0) || (full_size > 32'(MAX_SIZE))) begin
                            state_d = ST_ERR;
                            busy_d  = 1'b0;
                            error_d = 1'b1;
                        end else begin
                            state_d = ST_DATA;
                            rem_d   = full_size;
                        end
                    end
                end
            end

            ST_DATA: begin
                if (mem_valid_q) begin
                    if (mem_ready) begin
                        mem_valid_d = 1'b0;
                        ptr_d       = ptr_q + ADDR_W'(4);
                        lane_d      = 2'd0;
                        wdata_d     = '0;
                        wstrb_d     = '0;
                        if (rem_q == 32'd0) begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end else if (rx_valid && (rem_q != 32'd0)) begin
                    wdata_d[8*lane_q +: 8] = rx_data;
                    wstrb_d[lane_q]        = 1'b1;
                    lane_d                 = lane_q + 2'd1;
                    rem_d                  = rem_q - 32'd1;
                    // word complete or last byte of the file: present it next cycle
                    if ((lane_q == 2'd3) || (rem_q == 32'd1)) begin
                        mem_valid_d = 1'b1;
                    end
                end
            end

            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            rem_q       <= 32'd0;
            size_q      <= 32'd0;
            size_cnt_q  <= 2'd0;
            lane_q      <= 2'd0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            mem_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            size_q      <= size_d;
            size_cnt_q  <= size_cnt_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            mem_valid_q <= mem_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

endmodule
